// File: rtl/lfsr_rng_sched.sv
// Round-robin scheduler sharing one x^6+x^5+1 LFSR between NREQ requesters.
// Each grant returns the current word, then advances the LFSR STRIDE steps.
module lfsr_rng_sched #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned STRIDE = 1,
   parameter logic [5:0]  SEED   = 6'b110101
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            seed_load,
   input  logic [5:0]      seed_val,
   output logic [NREQ-1:0] gnt,
   output logic [5:0]      rnd,
   output logic            rnd_valid,
   output logic            busy,
   output logic            seed_err,
   output logic            period_wrap
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GRANT, S_ADVANCE} state_e;

   state_e          state_q, state_d;
   logic [5:0]      lfsr_q, lfsr_d;
   logic [5:0]      step_q, step_d;
   logic [3:0]      adv_q, adv_d;
   logic [IW-1:0]   last_q, last_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [5:0]      rnd_q, rnd_d;
   logic            rnd_valid_q, rnd_valid_d;
   logic            seed_err_q, seed_err_d;
   logic            wrap_q, wrap_d;

   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic            win_found;
   logic            stepping;

   function automatic logic [5:0] lfsr_step(input logic [5:0] q);
      return {q[0] ^ q[1], q[5:1]};
   endfunction

   // Round-robin search starting one past the last winner.
   always_comb begin
      win_idx   = last_q;
      win_found = 1'b0;
      cand      = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = IW'((32'(last_q) + i) % NREQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      step_d      = step_q;
      adv_d       = adv_q;
      last_d      = last_q;
      gnt_d       = '0;
      rnd_d       = rnd_q;
      rnd_valid_d = 1'b0;
      seed_err_d  = 1'b0;
      wrap_d      = 1'b0;
      stepping    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (seed_load) begin
               state_d = S_LOAD;
            end else if (win_found) begin
               state_d     = S_GRANT;
               last_d      = win_idx;
               gnt_d       = NREQ'(1) << win_idx;
               rnd_d       = lfsr_q;
               rnd_valid_d = 1'b1;
            end
         end
         S_LOAD: begin
            lfsr_d     = (seed_val == '0) ? SEED : seed_val;
            step_d     = '0;
            seed_err_d = (seed_val == '0);
            state_d    = S_IDLE;
         end
         S_GRANT: begin
            stepping = 1'b1;
            adv_d    = 4'(STRIDE - 1);
            state_d  = (STRIDE > 1) ? S_ADVANCE : S_IDLE;
         end
         S_ADVANCE: begin
            stepping = 1'b1;
            adv_d    = adv_q - 4'd1;
            if (adv_q == 4'd1) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (stepping) begin
         lfsr_d = lfsr_step(lfsr_q);
         step_d = (step_q == 6'd62) ? '0 : step_q + 6'd1;
      end

      if (lfsr_q == '0) begin
         lfsr_d     = SEED;
         step_d     = '0;
         seed_err_d = 1'b1;
      end

      // Registered look-ahead: the pulse lands in the cycle whose step wraps,
      // so on a grant it coincides with rnd_valid.
      wrap_d = ((state_d == S_GRANT) || (state_d == S_ADVANCE)) && (step_d == 6'd62);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         lfsr_q      <= SEED;
         step_q      <= '0;
         adv_q       <= '0;
         last_q      <= IW'(NREQ - 1);
         gnt_q       <= '0;
         rnd_q       <= '0;
         rnd_valid_q <= 1'b0;
         seed_err_q  <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         step_q      <= step_d;
         adv_q       <= adv_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         rnd_q       <= rnd_d;
         rnd_valid_q <= rnd_valid_d;
         seed_err_q  <= seed_err_d;
         wrap_q      <= wrap_d;
      end
   end

   assign gnt         = gnt_q;
   assign rnd         = rnd_q;
   assign rnd_valid   = rnd_valid_q;
   assign seed_err    = seed_err_q;
   assign period_wrap = wrap_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_lfsr_rng_sched.sv
// Directed bench for lfsr_rng_sched: STRIDE=1 instance for most checks,
// STRIDE=4 instance for grant spacing and reset during ADVANCE.
module tb_lfsr_rng_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [3:0] req, req4;
   logic       seed_load, seed_load4;
   logic [5:0] seed_val, seed_val4;

   logic [3:0] gnt, gnt4;
   logic [5:0] rnd, rnd4;
   logic       rnd_valid, rnd_valid4, busy, busy4;
   logic       seed_err, seed_err4, period_wrap, period_wrap4;

   lfsr_rng_sched #(.NREQ(4), .STRIDE(1), .SEED(6'b110101)) dut (
      .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_val(seed_val),
      .gnt(gnt), .rnd(rnd), .rnd_valid(rnd_valid), .busy(busy),
      .seed_err(seed_err), .period_wrap(period_wrap));

   lfsr_rng_sched #(.NREQ(4), .STRIDE(4), .SEED(6'b110101)) dut4 (
      .clk(clk), .reset(reset), .req(req4), .seed_load(seed_load4), .seed_val(seed_val4),
      .gnt(gnt4), .rnd(rnd4), .rnd_valid(rnd_valid4), .busy(busy4),
      .seed_err(seed_err4), .period_wrap(period_wrap4));

   localparam logic [5:0] SEED = 6'b110101;

   int tests  = 0;
   int failed = 0;
   int wrap_total = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [5:0] rnd;
   } vec_t;

   vec_t vt[10];

   function automatic logic [5:0] model_step(input logic [5:0] q);
      return {q[0] ^ q[1], q[5:1]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = '0; req4 = '0;
      seed_load = 1'b0; seed_load4 = 1'b0;
      seed_val = '0; seed_val4 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_grant(input bit use4, output logic [3:0] g, output logic [5:0] r,
                             output int gap, output logic w);
      bit found = 1'b0;
      g = '0; r = '0; gap = 0; w = 1'b0;
      for (int c = 1; c <= 20 && !found; c++) begin
         @(negedge clk);
         if (use4) begin
            if (rnd_valid4) begin found = 1'b1; g = gnt4; r = rnd4; gap = c; end
         end else begin
            wrap_total += int'(period_wrap);
            if (rnd_valid) begin found = 1'b1; g = gnt; r = rnd; gap = c; w = period_wrap; end
         end
      end
      check("grant_seen", 32'(found), 32'd1);
   endtask

   initial begin
      logic [3:0] g;
      logic [5:0] r, cur;
      logic       w;
      int         gap, pulses, wrap_at, zeros;
      logic [5:0] seq0[3];

      vt[0] = '{4'b1111, 4'b0001, 6'b110101};
      vt[1] = '{4'b1111, 4'b0010, 6'b111010};
      vt[2] = '{4'b1111, 4'b0100, 6'b111101};
      vt[3] = '{4'b1111, 4'b1000, 6'b111110};
      vt[4] = '{4'b1111, 4'b0001, 6'b111111};
      vt[5] = '{4'b1101, 4'b0100, 6'b011111};
      vt[6] = '{4'b1101, 4'b1000, 6'b001111};
      vt[7] = '{4'b1101, 4'b0001, 6'b000111};
      vt[8] = '{4'b0001, 4'b0001, 6'b000011};
      vt[9] = '{4'b0001, 4'b0001, 6'b000001};
      seq0[0] = 6'b110101; seq0[1] = 6'b111010; seq0[2] = 6'b111101;

      // Reset state
      do_reset();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rnd", 32'(rnd), 32'd0);
      check("rst_rnd_valid", 32'(rnd_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_seed_err", 32'(seed_err), 32'd0);
      check("rst_period_wrap", 32'(period_wrap), 32'd0);

      // Held single request: rnd_valid every second cycle
      req = 4'b0001;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check("hold_valid", 32'(rnd_valid), 32'(c % 2));
         if (c % 2 == 1) begin
            check("hold_rnd", 32'(rnd), 32'(seq0[(c - 1) / 2]));
            check("hold_gnt", 32'(gnt), 32'd1);
         end
         if (c == 1) check("hold_busy_grant", 32'(busy), 32'd1);
         if (c == 2) check("hold_busy_idle", 32'(busy), 32'd0);
      end
      req = '0;

      // Fairness table
      do_reset();
      for (int i = 0; i < 10; i++) begin
         req = vt[i].req;
         wait_grant(1'b0, g, r, gap, w);
         check($sformatf("tbl%0d_gnt", i), 32'(g), 32'(vt[i].gnt));
         check($sformatf("tbl%0d_rnd", i), 32'(r), 32'(vt[i].rnd));
      end
      req = '0;
      @(negedge clk);

      // Zero seed falls back to SEED
      seed_load = 1'b1; seed_val = 6'b000000;
      pulses = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check("load_busy", 32'(busy), 32'd1);
            seed_load = 1'b0;
         end
         pulses += int'(seed_err);
      end
      check("zero_seed_err_pulses", 32'(pulses), 32'd1);
      req = 4'b0001;
      wait_grant(1'b0, g, r, gap, w);
      check("zero_seed_rnd", 32'(r), 32'(SEED));
      req = '0;
      @(negedge clk);

      // Nonzero seed, grant requested two cycles after seed_load
      seed_load = 1'b1; seed_val = 6'b000001;
      @(negedge clk);
      seed_load = 1'b0;
      pulses = int'(seed_err);
      @(negedge clk);
      pulses += int'(seed_err);
      req = 4'b0001;
      wait_grant(1'b0, g, r, gap, w);
      check("seed1_rnd", 32'(r), 32'd1);
      check("seed1_gap", 32'(gap), 32'd1);
      check("seed1_no_err", 32'(pulses), 32'd0);
      req = '0;
      @(negedge clk);

      // Lockup guard
      force dut.lfsr_q = 6'b000000;
      #1 release dut.lfsr_q;
      @(negedge clk);
      check("lockup_seed_err", 32'(seed_err), 32'd1);
      @(negedge clk);
      check("lockup_seed_err_clear", 32'(seed_err), 32'd0);
      req = 4'b0001;
      wait_grant(1'b0, g, r, gap, w);
      check("lockup_rnd", 32'(r), 32'(SEED));
      req = '0;
      @(negedge clk);

      // seed_load beats req; grant two cycles later returns new seed
      seed_load = 1'b1; seed_val = 6'b101010; req = 4'b0010;
      @(negedge clk);
      check("both_load_gnt", 32'(gnt), 32'd0);
      check("both_load_busy", 32'(busy), 32'd1);
      seed_load = 1'b0;
      @(negedge clk);
      check("both_idle_valid", 32'(rnd_valid), 32'd0);
      @(negedge clk);
      check("both_gnt", 32'(gnt), 32'b0010);
      check("both_rnd", 32'(r | rnd), 32'(r | 6'b101010));
      check("both_rnd_exact", 32'(rnd), 32'b101010);
      req = '0;

      // Full period
      do_reset();
      wrap_total = 0; wrap_at = 0; zeros = 0;
      cur = SEED;
      req = 4'b0001;
      for (int k = 1; k <= 64; k++) begin
         wait_grant(1'b0, g, r, gap, w);
         check($sformatf("period_rnd%0d", k), 32'(r), 32'(cur));
         cur = model_step(cur);
         if (w) wrap_at = k;
         if (k <= 63 && r == 6'b0) zeros++;
         if (k == 64) check("period_64th_is_seed", 32'(r), 32'(SEED));
      end
      req = '0;
      check("period_wrap_count", 32'(wrap_total), 32'd1);
      check("period_wrap_at", 32'(wrap_at), 32'd63);
      check("period_no_zero", 32'(zeros), 32'd0);

      // STRIDE=4: spacing and reset mid-ADVANCE
      do_reset();
      req4 = 4'b0001;
      wait_grant(1'b1, g, r, gap, w);
      check("s4_first_rnd", 32'(r), 32'(SEED));
      wait_grant(1'b1, g, r, gap, w);
      check("s4_gap", 32'(gap), 32'd5);
      check("s4_second_rnd", 32'(r), 32'b111111);
      check("s4_second_gnt", 32'(g), 32'b0001);
      @(negedge clk);
      @(negedge clk);
      check("s4_busy_adv2", 32'(busy4), 32'd1);
      reset = 1'b1;
      #1;
      check("s4_rst_busy", 32'(busy4), 32'd0);
      check("s4_rst_gnt", 32'(gnt4), 32'd0);
      check("s4_rst_valid", 32'(rnd_valid4), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      req4 = 4'b1111;
      wait_grant(1'b1, g, r, gap, w);
      check("s4_post_gnt", 32'(g), 32'b0001);
      check("s4_post_rnd", 32'(r), 32'(SEED));
      req4 = '0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
